// File: rtl/stb_wdt_pkg.sv
// Shared types and default constants for the strobe-tick watchdog.
package stb_wdt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        WARN  = 2'd2,
        BITE  = 2'd3
    } wdt_state_t;

    localparam int DEF_TIMEOUT_TICKS = 8;
    localparam int DEF_WARN_TICKS    = 2;
    localparam int DEF_CNT_W         = 8;

    // Countdown step that never wraps below zero.
    function automatic int sat_dec(input int value);
        return (value > 0) ? value - 1 : 0;
    endfunction

endpackage

// File: rtl/stb_edge_tick.sv
// Turns each level change of the board strobe into a one-cycle registered tick.
// Build option STB_WDT_SYNC_EN inserts a 2-flop synchronizer ahead of the edge detector.
module stb_edge_tick (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_stb_toggle,
    output logic o_tick
);

    logic       stb_s;
    logic       stb_q;
    logic [1:0] prime_cnt;
    logic       primed;

`ifdef STB_WDT_SYNC_EN
    localparam logic [1:0] PRIME_CYCLES = 2'd3;

    logic sync_1;
    logic sync_2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= i_stb_toggle;
            sync_2 <= sync_1;
        end
    end

    assign stb_s = sync_2;
`else
    localparam logic [1:0] PRIME_CYCLES = 2'd1;

    assign stb_s = i_stb_toggle;
`endif

    // Priming holds off edge detection until stb_q holds a real sample,
    // so a strobe already high at reset release does not fake a tick.
    assign primed = (prime_cnt == PRIME_CYCLES);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stb_q     <= 1'b0;
            prime_cnt <= 2'd0;
            o_tick    <= 1'b0;
        end else begin
            stb_q  <= stb_s;
            o_tick <= primed & (stb_s ^ stb_q);
            if (!primed) begin
                prime_cnt <= prime_cnt + 2'd1;
            end
        end
    end

endmodule

// File: rtl/stb_watchdog.sv
// Tick-based watchdog driven by strobe toggles: kick within TIMEOUT_TICKS or WARN then sticky BITE.
// Build option STB_WDT_SYNC_EN (see stb_edge_tick) synchronizes the incoming strobe.
module stb_watchdog
    import stb_wdt_pkg::*;
#(
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int WARN_TICKS    = DEF_WARN_TICKS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stb_toggle,
    input  logic             i_enable,
    input  logic             i_kick,
    input  logic             i_clear,
    output logic             o_tick,
    output logic             o_warn,
    output logic             o_bite,
    output logic [CNT_W-1:0] o_ticks_left,
    output logic [1:0]       o_state
);

    if (!((WARN_TICKS > 0) && (WARN_TICKS < TIMEOUT_TICKS) &&
          (CNT_W < 31) && (TIMEOUT_TICKS < (1 << CNT_W)))) begin : g_param_err
        $error("stb_watchdog: require 0 < WARN_TICKS < TIMEOUT_TICKS < 2**CNT_W");
    end

    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] WARN_LVL = CNT_W'(WARN_TICKS);

    wdt_state_t       state_q;
    wdt_state_t       state_d;
    logic [CNT_W-1:0] left_q;
    logic [CNT_W-1:0] left_d;
    logic [CNT_W-1:0] left_dec;
    logic             tick;
    logic             warn_q;
    logic             bite_q;

    stb_edge_tick u_edge_tick (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_stb_toggle (i_stb_toggle),
        .o_tick       (tick)
    );

    assign left_dec = CNT_W'(sat_dec(int'(left_q)));

    // Next-state rules; disable beats kick, and kick beats a same-cycle tick.
    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        unique case (state_q)
            IDLE: begin
                left_d = RELOAD;
                if (i_enable) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!i_enable) begin
                    state_d = IDLE;
                    left_d  = RELOAD;
                end else if (i_kick) begin
                    left_d = RELOAD;
                end else if (tick) begin
                    left_d = left_dec;
                    if (left_dec <= WARN_LVL) begin
                        state_d = WARN;
                    end
                end
            end
            WARN: begin
                if (!i_enable) begin
                    state_d = IDLE;
                    left_d  = RELOAD;
                end else if (i_kick) begin
                    state_d = ARMED;
                    left_d  = RELOAD;
                end else if (tick) begin
                    left_d = left_dec;
                    if (left_dec == '0) begin
                        state_d = BITE;
                    end
                end
            end
            BITE: begin
                left_d = '0;
                if (i_clear) begin
                    state_d = IDLE;
                    left_d  = RELOAD;
                end
            end
            default: begin
                state_d = IDLE;
                left_d  = RELOAD;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            left_q  <= RELOAD;
            warn_q  <= 1'b0;
            bite_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            warn_q  <= (state_d == WARN);
            bite_q  <= (state_d == BITE);
        end
    end

    assign o_tick       = tick;
    assign o_warn       = warn_q;
    assign o_bite       = bite_q;
    assign o_ticks_left = left_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_stb_watchdog.sv
// Randomized self-checking bench for stb_watchdog against a behavioural model.
// Honours STB_WDT_SYNC_EN for tick latency and priming delay.
module tb_stb_watchdog;

    localparam int TO   = 8;
    localparam int WN   = 2;
    localparam int CW   = 8;
`ifdef STB_WDT_SYNC_EN
    localparam int DLY   = 2;
    localparam int PRIME = 3;
`else
    localparam int DLY   = 0;
    localparam int PRIME = 1;
`endif
    localparam int LAT = DLY + 1;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_stb_toggle;
    logic          i_enable;
    logic          i_kick;
    logic          i_clear;
    logic          o_tick;
    logic          o_warn;
    logic          o_bite;
    logic [CW-1:0] o_ticks_left;
    logic [1:0]    o_state;

    always #5 i_clk = ~i_clk;

    stb_watchdog #(
        .TIMEOUT_TICKS (TO),
        .WARN_TICKS    (WN),
        .CNT_W         (CW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_stb_toggle (i_stb_toggle),
        .i_enable     (i_enable),
        .i_kick       (i_kick),
        .i_clear      (i_clear),
        .o_tick       (o_tick),
        .o_warn       (o_warn),
        .o_bite       (o_bite),
        .o_ticks_left (o_ticks_left),
        .o_state      (o_state)
    );

    int n_checks   = 0;
    int n_fail     = 0;
    int tick_count = 0;
    bit compare_en = 0;

    // Model: 0 idle, 1 armed, 2 warn, 3 bite; tick derived from the input sample history.
    int m_state = 0;
    int m_left  = TO;
    bit m_tick  = 0;
    bit hist[$];

    task automatic check_output(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge i_clk or posedge i_rst) begin
        bit t;
        int n;
        if (i_rst) begin
            m_state = 0;
            m_left  = TO;
            m_tick  = 0;
            hist.delete();
        end else begin
            t = m_tick;
            hist.push_back(i_stb_toggle);
            n = hist.size();
            m_tick = 0;
            if (n > PRIME) m_tick = (hist[n-DLY-1] != hist[n-DLY-2]);
            if (m_state == 3) begin
                m_left = 0;
                if (i_clear) begin m_state = 0; m_left = TO; end
            end else if (m_state == 0) begin
                m_left = TO;
                if (i_enable) m_state = 1;
            end else if (!i_enable) begin
                m_state = 0;
                m_left  = TO;
            end else if (i_kick) begin
                m_state = 1;
                m_left  = TO;
            end else if (t) begin
                m_left = (m_left > 0) ? m_left - 1 : 0;
                if (m_left == 0) m_state = 3;
                else if (m_left <= WN) m_state = 2;
            end
        end
    end

    always @(negedge i_clk) begin
        if (o_tick) tick_count++;
        if (compare_en) begin
            check_output("cmp_tick", int'(o_tick), int'(m_tick));
            check_output("cmp_warn", int'(o_warn), int'(m_state == 2));
            check_output("cmp_bite", int'(o_bite), int'(m_state == 3));
            check_output("cmp_left", int'(o_ticks_left), m_left);
            check_output("cmp_state", int'(o_state), m_state);
        end
    end

    task automatic apply_stimulus(input logic stb, input logic en, input logic kick, input logic clr);
        @(negedge i_clk);
        #2;
        i_stb_toggle = stb;
        i_enable     = en;
        i_kick       = kick;
        i_clear      = clr;
    endtask

    task automatic toggle_wait();
        apply_stimulus(~i_stb_toggle, i_enable, 1'b0, 1'b0);
        repeat (DLY + 2) @(negedge i_clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit found;
        i_stb_toggle = 1'b1;
        i_enable     = 1'b0;
        i_kick       = 1'b0;
        i_clear      = 1'b0;
        i_rst        = 1'b0;
        #1 i_rst = 1'b1;
        compare_en = 1;
        repeat (3) @(negedge i_clk);
        #2 i_rst = 1'b0;
        tick_count = 0;

        // Strobe high through reset must not produce a tick
        repeat (20) @(negedge i_clk);
        #1 check_output("no_tick_when_high", tick_count, 0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge i_clk);
            check_output("tick_latency", int'(o_tick), int'(i == LAT));
        end
        repeat (3) @(negedge i_clk);
        #1 check_output("single_tick", tick_count, 1);

        // Countdown into WARN then BITE
        apply_stimulus(i_stb_toggle, 1'b1, 1'b0, 1'b0);
        @(negedge i_clk);
        check_output("armed_state", int'(o_state), 1);
        check_output("armed_left", int'(o_ticks_left), 8);
        for (int i = 1; i <= 6; i++) begin
            toggle_wait();
            check_output("countdown", int'(o_ticks_left), 8 - i);
        end
        check_output("warn_after_6", int'(o_warn), 1);
        toggle_wait();
        toggle_wait();
        check_output("bite_set", int'(o_bite), 1);
        check_output("bite_left", int'(o_ticks_left), 0);
        check_output("bite_warn_off", int'(o_warn), 0);

        // Kick out of WARN at ticks_left=1
        apply_stimulus(i_stb_toggle, 1'b1, 1'b0, 1'b1);
        apply_stimulus(i_stb_toggle, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) toggle_wait();
        check_output("warn_left1", int'(o_ticks_left), 1);
        check_output("warn_state", int'(o_state), 2);
        apply_stimulus(i_stb_toggle, 1'b1, 1'b1, 1'b0);
        apply_stimulus(i_stb_toggle, 1'b1, 1'b0, 1'b0);
        check_output("kick_state", int'(o_state), 1);
        check_output("kick_left", int'(o_ticks_left), 8);
        check_output("kick_warn", int'(o_warn), 0);

        // Kick and tick in the same cycle at ticks_left=5
        for (int i = 0; i < 3; i++) toggle_wait();
        check_output("left5", int'(o_ticks_left), 5);
        apply_stimulus(~i_stb_toggle, 1'b1, 1'b0, 1'b0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge i_clk);
            if (o_tick) found = 1;
        end
        check_output("tick_seen", int'(found), 1);
        #2 i_kick = 1'b1;
        @(negedge i_clk);
        #2 i_kick = 1'b0;
        check_output("kick_beats_tick", int'(o_ticks_left), 8);

        // BITE ignores kick, disable and ticks; only clear exits
        for (int i = 0; i < 8; i++) toggle_wait();
        check_output("bite_again", int'(o_state), 3);
        apply_stimulus(i_stb_toggle, 1'b0, 1'b1, 1'b0);
        apply_stimulus(i_stb_toggle, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) toggle_wait();
        check_output("bite_sticky", int'(o_state), 3);
        check_output("bite_sticky_left", int'(o_ticks_left), 0);
        apply_stimulus(i_stb_toggle, 1'b0, 1'b0, 1'b1);
        apply_stimulus(i_stb_toggle, 1'b0, 1'b0, 1'b0);
        check_output("clear_state", int'(o_state), 0);
        check_output("clear_bite", int'(o_bite), 0);
        check_output("clear_left", int'(o_ticks_left), 8);

        // Asynchronous reset between edges while in WARN
        apply_stimulus(i_stb_toggle, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) toggle_wait();
        check_output("pre_rst_warn", int'(o_warn), 1);
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        check_output("async_rst_warn", int'(o_warn), 0);
        check_output("async_rst_left", int'(o_ticks_left), 8);
        check_output("async_rst_state", int'(o_state), 0);
        @(negedge i_clk);
        #2 i_rst = 1'b0;

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clk);
            #2;
            i_rst        = ($urandom_range(0, 299) == 0);
            i_stb_toggle = i_stb_toggle ^ ($urandom_range(0, 1) == 0);
            i_enable     = ($urandom_range(0, 15) != 0);
            i_kick       = ($urandom_range(0, 39) == 0);
            i_clear      = ($urandom_range(0, 7) == 0);
        end
        @(negedge i_clk);
        #2 i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
